// File: rtl/imem_fetch_banked_pkg.sv
// Shared constants and the fetch-response record for the banked instruction memory.
package imem_pkg;

    localparam int XLEN        = 32;
    localparam int MAX_FETCH_W = 2;

    localparam logic [XLEN-1:0] NOP_INST = 32'h00000013;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    // Sized for the widest legal fetch; narrower builds leave the upper slot unused.
    typedef struct packed {
        logic [XLEN-1:0]                   pc;
        logic [MAX_FETCH_W-1:0][XLEN-1:0]  inst;
        logic [MAX_FETCH_W-1:0]            mask;
        logic                              fault;
    } fetch_resp_t;

endpackage

// File: rtl/imem_fetch_banked_if.sv
// Fetch request/response, flush and program-load signals between the fetch stage and the IMEM.
interface imem_fetch_banked_if #(
    parameter int XLEN    = 32,
    parameter int FETCH_W = 2
);
    logic                    req_valid;
    logic                    req_ready;
    logic [XLEN-1:0]         req_addr;
    logic                    flush;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [XLEN-1:0]         resp_pc;
    logic [FETCH_W*XLEN-1:0] resp_inst;
    logic [FETCH_W-1:0]      resp_mask;
    logic                    resp_fault;
    logic                    prog_we;
    logic [XLEN-1:0]         prog_addr;
    logic [XLEN-1:0]         prog_data;

    modport master (
        output req_valid, req_addr, flush, resp_ready, prog_we, prog_addr, prog_data,
        input  req_ready, resp_valid, resp_pc, resp_inst, resp_mask, resp_fault
    );

    modport slave (
        input  req_valid, req_addr, flush, resp_ready, prog_we, prog_addr, prog_data,
        output req_ready, resp_valid, resp_pc, resp_inst, resp_mask, resp_fault
    );
endinterface

// File: rtl/imem_fetch_banked_bank.sv
// One interleaved IMEM bank: synchronous read-first read port plus a write port.
module imem_bank #(
    parameter int              XLEN     = 32,
    parameter int              ROWS     = 128,
    parameter int              RW       = 7,
    parameter logic [XLEN-1:0] NOP_INST = 32'h00000013
) (
    input  logic            clk,
    input  logic            we,
    input  logic [RW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic            re,
    input  logic [RW-1:0]   raddr,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [ROWS] = '{default: NOP_INST};

    // Both updates are non-blocking, so a same-edge write never reaches the read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_fetch_banked.sv
// Banked synchronous-read IMEM returning up to FETCH_W consecutive instructions per fetch.
// Optional IMEM_FETCH_TRACE_EN prints each delivered fetch bundle in simulation.
module imem_fetch_banked #(
    parameter int          XLEN     = 32,
    parameter int          DEPTH    = 256,
    parameter int          FETCH_W  = 2,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input logic               clk,
    input logic               rst,
    imem_fetch_banked_if.slave bus
);
    import imem_pkg::*;

    localparam int ROWS = DEPTH / FETCH_W;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int BW   = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;

    logic               accept;
    logic [XLEN-1:0]    word_idx;
    logic [XLEN-1:0]    prog_idx;
    logic               misaligned;
    logic               slot0_oob;
    logic               prog_ok;
    logic [FETCH_W-1:0] mask_d;
    logic [BW-1:0]      base_d;

    logic               valid_q;
    logic [XLEN-1:0]    pc_q;
    logic [FETCH_W-1:0] mask_q;
    logic               fault_q;
    logic [BW-1:0]      base_q;

    logic [XLEN-1:0]    bank_rdata [FETCH_W];
    fetch_resp_t        resp;

    assign bus.req_ready = !rst && !bus.flush && (!valid_q || bus.resp_ready);
    assign accept        = bus.req_valid && bus.req_ready;

    assign word_idx   = {2'b00, bus.req_addr[XLEN-1:2]};
    assign misaligned = bus.req_addr[1:0] != 2'b00;
    assign slot0_oob  = word_idx >= XLEN'(DEPTH);
    assign base_d     = BW'(word_idx % XLEN'(FETCH_W));

    assign prog_idx = {2'b00, bus.prog_addr[XLEN-1:2]};
    assign prog_ok  = bus.prog_we && (bus.prog_addr[1:0] == 2'b00) && (prog_idx < XLEN'(DEPTH));

    // Slots past the top of memory are dropped rather than wrapped to word 0.
    always_comb begin
        mask_d = '0;
        for (int k = 0; k < FETCH_W; k++) begin
            mask_d[k] = !misaligned && !slot0_oob && ((word_idx + XLEN'(k)) < XLEN'(DEPTH));
        end
    end

    // Each bank fetches whichever of the next FETCH_W words lands in it, so banks ahead
    // of the starting bank read one row further on.
    for (genvar j = 0; j < FETCH_W; j++) begin : g_bank
        logic [XLEN-1:0] rd_word;
        logic            bank_we;

        assign rd_word = word_idx
                       + ((XLEN'(j) + XLEN'(FETCH_W) - XLEN'(base_d)) % XLEN'(FETCH_W));
        assign bank_we = prog_ok && ((prog_idx % XLEN'(FETCH_W)) == XLEN'(j));

        imem_bank #(
            .XLEN    (XLEN),
            .ROWS    (ROWS),
            .RW      (RW),
            .NOP_INST(NOP_INST)
        ) u_bank (
            .clk  (clk),
            .we   (bank_we),
            .waddr(RW'(prog_idx / XLEN'(FETCH_W))),
            .wdata(bus.prog_data),
            .re   (accept),
            .raddr(RW'(rd_word / XLEN'(FETCH_W))),
            .rdata(bank_rdata[j])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            mask_q  <= '0;
            fault_q <= 1'b0;
            base_q  <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            pc_q    <= bus.req_addr;
            mask_q  <= mask_d;
            fault_q <= misaligned || slot0_oob;
            base_q  <= base_d;
        end else if (bus.resp_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Bank data stays in the bank read registers; masked-off slots show NOP instead.
    always_comb begin
        resp       = '0;
        resp.pc    = pc_q;
        resp.fault = fault_q;
        for (int k = 0; k < MAX_FETCH_W; k++) begin
            resp.inst[k] = NOP_INST;
        end
        for (int k = 0; k < FETCH_W; k++) begin
            resp.mask[k] = mask_q[k];
            if (mask_q[k]) begin
                resp.inst[k] = bank_rdata[(int'(base_q) + k) % FETCH_W];
            end
        end
    end

    assign bus.resp_valid = valid_q;
    assign bus.resp_pc    = resp.pc;
    assign bus.resp_inst  = resp.inst[FETCH_W-1:0];
    assign bus.resp_mask  = resp.mask[FETCH_W-1:0];
    assign bus.resp_fault = resp.fault;

`ifdef IMEM_FETCH_TRACE_EN
    logic trace_q;

    always_ff @(posedge clk) begin
        trace_q <= rst ? 1'b0 : accept;
    end

    always @(negedge clk) begin
        if (trace_q && valid_q) begin
            $write("IMEM_FETCH: pc=%h mask=%b fault=%b", bus.resp_pc, bus.resp_mask, bus.resp_fault);
            for (int k = 0; k < FETCH_W; k++) begin
                $write(" %h", bus.resp_inst[k*XLEN +: XLEN]);
            end
            $write("\n");
        end
    end
`else
    // Trace output not built.
`endif

endmodule

// File: tb/tb_imem_fetch_banked.sv
// Randomised bench for imem_fetch_banked against a word-array reference model.
module tb_imem_fetch_banked;
    import imem_pkg::*;

    localparam int DEPTH   = 256;
    localparam int FETCH_W = 2;
    localparam int W       = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    imem_fetch_banked_if #(.XLEN(W), .FETCH_W(FETCH_W)) bus();

    imem_fetch_banked #(
        .XLEN    (W),
        .DEPTH   (DEPTH),
        .FETCH_W (FETCH_W),
        .NOP_INST(NOP_INST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] prog [10];

    bit          exp_valid;
    bit          exp_known;
    logic [31:0] exp_pc;
    logic [63:0] exp_inst;
    logic [1:0]  exp_mask;
    bit          exp_fault;

    int check_count = 0;
    int error_count = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        exp_valid = 1'b0;
        exp_known = 1'b1;
        exp_pc    = '0;
        exp_inst  = {NOP_INST, NOP_INST};
        exp_mask  = '0;
        exp_fault = 1'b0;
    endtask

    // One clock cycle: drive, check the current outputs, then advance the model past the edge.
    task automatic applyStimulus(input bit s_rst, input bit rv, input logic [31:0] addr,
                                 input bit fl, input bit rr, input bit we,
                                 input logic [31:0] paddr, input logic [31:0] pdata);
        bit          exp_ready;
        logic [31:0] w;
        logic [31:0] pw;
        rst            = s_rst;
        bus.req_valid  = rv;
        bus.req_addr   = addr;
        bus.flush      = fl;
        bus.resp_ready = rr;
        bus.prog_we    = we;
        bus.prog_addr  = paddr;
        bus.prog_data  = pdata;
        #2;
        exp_ready = !s_rst && !fl && (!exp_valid || rr);
        checkOutput("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        checkOutput("resp_valid", 64'(bus.resp_valid), 64'(exp_valid));
        if (exp_known) begin
            checkOutput("resp_pc", 64'(bus.resp_pc), 64'(exp_pc));
            checkOutput("resp_inst", bus.resp_inst, exp_inst);
            checkOutput("resp_mask", 64'(bus.resp_mask), 64'(exp_mask));
            checkOutput("resp_fault", 64'(bus.resp_fault), 64'(exp_fault));
        end
        if (s_rst) begin
            modelReset();
        end else if (fl) begin
            exp_valid = 1'b0;
            exp_known = 1'b0;
        end else if (rv && exp_ready) begin
            w         = addr >> 2;
            exp_valid = 1'b1;
            exp_known = 1'b1;
            exp_pc    = addr;
            exp_inst  = {NOP_INST, NOP_INST};
            exp_mask  = '0;
            exp_fault = (addr[1:0] != 2'b00) || (w >= DEPTH);
            if (!exp_fault) begin
                for (int k = 0; k < FETCH_W; k++) begin
                    if (w + k < DEPTH) begin
                        exp_mask[k]          = 1'b1;
                        exp_inst[k*32 +: 32] = ref_mem[w + k];
                    end
                end
            end
        end else if (rr && exp_valid) begin
            exp_valid = 1'b0;
            exp_known = 1'b0;
        end
        pw = paddr >> 2;
        if (we && paddr[1:0] == 2'b00 && pw < DEPTH) begin
            ref_mem[pw] = pdata;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] randAddr();
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            6:       return ($urandom_range(0, 1) == 0) ? 32'h3FC : 32'h3F8;
            7:       return ($urandom_range(0, DEPTH - 1) << 2) | 32'($urandom_range(1, 3));
            8:       return 32'($urandom_range(DEPTH, DEPTH + 20)) << 2;
            9:       return 32'($urandom_range(0, 15)) << 2;
            default: return 32'($urandom_range(0, DEPTH - 1)) << 2;
        endcase
    endfunction

    initial begin
        prog[0] = {12'd0,   5'd0, 3'b000, 5'd1, OP_IMM};
        prog[1] = {12'd5,   5'd0, 3'b000, 5'd2, OP_IMM};
        prog[2] = {12'd32,  5'd0, 3'b000, 5'd3, OP_IMM};
        prog[3] = {12'd1,   5'd1, 3'b000, 5'd1, OP_IMM};
        prog[4] = 32'h00208463;
        prog[5] = 32'hff9ff06f;
        prog[6] = {12'd0,   5'd3, 3'b000, 5'd0, JALR};
        prog[7] = {12'd7,   5'd0, 3'b000, 5'd4, OP_IMM};
        prog[8] = 32'h0040006f;
        prog[9] = 32'h00000063;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = NOP_INST;
        if (prog[8][6:0] != JAL || prog[4][6:0] != BRANCH) $display("[TB] program encoding note");

        rst = 1'b1;
        bus.req_valid = 0; bus.req_addr = 0; bus.flush = 0; bus.resp_ready = 0;
        bus.prog_we = 0; bus.prog_addr = 0; bus.prog_data = 0;
        @(posedge clk);
        #1;
        modelReset();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 1, 1, 32'(i * 4), prog[i]);
        applyStimulus(0, 0, 0, 0, 1, 1, 32'h3FC, 32'h0ff00093);

        applyStimulus(0, 1, 32'h08, 0, 1, 0, 0, 0);
        checkOutput("plan_pc08", 64'(bus.resp_pc), 64'h08);
        checkOutput("plan_inst08", bus.resp_inst, {prog[3], prog[2]});
        checkOutput("plan_mask08", 64'(bus.resp_mask), 64'b11);
        applyStimulus(0, 1, 32'h0C, 0, 1, 0, 0, 0);
        checkOutput("plan_inst0c", bus.resp_inst, {prog[4], prog[3]});
        applyStimulus(0, 1, 32'h3FC, 0, 1, 0, 0, 0);
        checkOutput("plan_inst3fc", bus.resp_inst, {NOP_INST, 32'h0ff00093});
        checkOutput("plan_mask3fc", 64'(bus.resp_mask), 64'b01);
        applyStimulus(0, 1, 32'h400, 0, 1, 0, 0, 0);
        checkOutput("plan_fault400", 64'(bus.resp_fault), 64'd1);
        applyStimulus(0, 1, 32'h06, 0, 1, 0, 0, 0);
        checkOutput("plan_inst06", bus.resp_inst, {NOP_INST, NOP_INST});
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 32'h20, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 32'(i * 4), 0, 1, 0, 0, 0);

        applyStimulus(0, 1, 32'h10, 1, 1, 0, 0, 0);
        checkOutput("plan_flush", 64'(bus.resp_valid), 64'd0);
        applyStimulus(0, 1, 32'h08, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("plan_rst_inst", bus.resp_inst, {NOP_INST, NOP_INST});
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        applyStimulus(0, 1, 32'h10, 0, 1, 1, 32'h10, 32'h00100093);
        checkOutput("plan_readfirst", 64'(bus.resp_inst[31:0]), 64'(prog[4]));
        applyStimulus(0, 1, 32'h10, 0, 1, 0, 0, 0);
        checkOutput("plan_newdata", 64'(bus.resp_inst[31:0]), 64'h00100093);

        for (int i = 0; i < 400; i++) begin
            bit          r_rst;
            bit          r_we;
            logic [31:0] r_paddr;
            r_rst   = ($urandom_range(0, 49) == 0);
            r_we    = !r_rst && ($urandom_range(0, 4) == 0);
            r_paddr = ($urandom_range(0, 7) == 0) ? randAddr() | 32'($urandom_range(0, 3)) : randAddr();
            applyStimulus(r_rst, ($urandom_range(0, 9) < 7), randAddr(),
                          ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7),
                          r_we, r_paddr, $urandom());
        end
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/imem_fetch_banked.md
Name: imem_fetch_banked

Overview:
- Parametrised, synchronous-read instruction memory for the RV32I core.
- Replaces the single-word combinational IMEM.
- Returns up to FETCH_W consecutive instructions per request, for dual-issue fetch.
- Uses a valid/ready request/response handshake with one-cycle read latency.
- Provides a program-load write port and fault reporting for misaligned or out-of-range PCs.
- Sits between the PC/fetch stage and the inst1/inst2 decode registers.

Parameters:
- XLEN, 32, instruction and address width.
- DEPTH, 256, memory depth in words; must be a multiple of FETCH_W.
- FETCH_W, 2, instructions returned per fetch; legal values are 1 or 2.
- NOP_INST, 32'h00000013, fill and bubble value (ADDI x0,x0,0).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_addr  in  XLEN  byte address (PC) of slot 0.
- flush  in  1  discard any pending or in-flight response (branch/jump redirect).
- resp_valid  out  1  response registered and held until taken.
- resp_ready  in  1  consumer takes the response.
- resp_pc  out  XLEN  req_addr of the returned bundle.
- resp_inst  out  FETCH_W*XLEN  slot k at bits [k*XLEN +: XLEN]; slot k holds the word at resp_pc+4k.
- resp_mask  out  FETCH_W  per-slot valid.
- resp_fault  out  1  request was misaligned or slot 0 was out of range.
- prog_we  in  1  program-load write enable.
- prog_addr  in  XLEN  byte address for the write (word index = prog_addr[..:2]).
- prog_data  in  XLEN  word to write.

Behaviour:
- Reset values: resp_valid=0, resp_pc=0, every resp_inst slot=NOP_INST, resp_mask=0, resp_fault=0.
- req_ready = !resp_valid || resp_ready. This is a single output register, so full throughput is possible with no bubble when resp_ready is held high.
- Request accepted in cycle N: response visible in cycle N+1 (resp_valid=1).
- While resp_valid && !resp_ready, all resp_* outputs are held stable.
- Word index w = req_addr >> 2. Words are interleaved across FETCH_W banks: word w lives in bank (w mod FETCH_W), row (w / FETCH_W). Slot 1 reads the other bank, at row+1 when w is odd.
- Misaligned request (req_addr[1:0] != 0): resp_fault=1, resp_mask=0, all slots NOP_INST.
- Out-of-range slot 0 (w >= DEPTH): resp_fault=1, resp_mask=0, all slots NOP_INST.
- Slot k with w+k >= DEPTH while slot 0 is in range: resp_mask[k]=0, slot k=NOP_INST, resp_fault=0. There is no wrap-around to word 0.
- flush: in the next cycle resp_valid=0 and any accept in the flush cycle is dropped. req_ready is forced low during the flush cycle.
- flush together with resp_ready in the same cycle: flush wins and no response is delivered.
- prog_we: writes on the rising edge; an out-of-range or misaligned prog_addr is ignored.
- Write and fetch of the same word in the same cycle: the fetch returns the old data (read-first); the new data is visible from the next request.
- Memory contents: initialised to NOP_INST at time zero. rst does NOT clear memory. rst mid-operation drops the in-flight response; the next accept is legal in the cycle after rst deasserts.
- FETCH_W=1: resp_mask is 1 bit, and a single bank holds all words.

Optional Feature:
- Macro: IMEM_FETCH_TRACE_EN.
- Defined: on every accepted request, a simulation-only $display prints "IMEM_FETCH: pc=%h mask=%b fault=%b", followed by each slot's hex instruction, in the response cycle.
- Undefined: no display code is elaborated. RTL behaviour is identical either way.

Decomposition:
- imem_pkg holds:
  - XLEN, NOP_INST, RV32I opcode constants (OP_IMM, BRANCH, JAL, JALR);
  - a fetch-response struct typedef (pc, inst array, mask, fault).
- Sub-module imem_bank, instantiated FETCH_W times:
  - one synchronous read port, one write port, read-first;
  - DEPTH/FETCH_W rows.

Test Plan:
- Load words 0..9 via prog_we (the addi/beq/jal/jalr loop program); request pc=0x08 with resp_ready=1 -> next cycle resp_valid=1, resp_pc=0x08, slot0=word2, slot1=word3, mask=2'b11, fault=0.
- Request pc=0x0C (odd word) -> slot0=word3, slot1=word4 from the even bank's next row, mask=2'b11.
- Request pc=0x3FC with DEPTH=256 -> slot0=word255, slot1=NOP_INST, mask=2'b01, fault=0. Request pc=0x400 -> fault=1, mask=0.
- Request pc=0x06 -> fault=1, slots=32'h00000013. Hold resp_ready=0 for 3 cycles -> outputs stable, req_ready=0. Raise resp_ready -> taken; back-to-back requests then stream at 1 per cycle.
- Accept pc=0x10 and assert flush in the same cycle -> resp_valid=0 next cycle. Assert rst while resp_valid=1 -> resp_valid=0, resp_inst all 32'h00000013, resp_pc=0.
- In the same cycle, prog_we to word 4 with 32'h00100093 and a fetch of pc=0x10 -> old word returned; the following fetch of 0x10 returns 32'h00100093.
